// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight register writers per pipeline stage and
// decides, for the instruction in decode, whether to stall or where to forward from.
module hazard_scoreboard #(
    parameter int unsigned NREG  = 16,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned FW    = $clog2(DEPTH + 1),
    parameter int unsigned CW    = 16,
    localparam int unsigned RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic          issue_wb_en,
    input  logic          issue_is_load,
    input  logic [RW-1:0] issue_dest,
    input  logic [RW-1:0] src1,
    input  logic [RW-1:0] src2,
    input  logic          src1_used,
    input  logic          src2_used,
    input  logic          forward_en,
    input  logic          flush,
    output logic          stall,
    output logic [FW-1:0] fwd_sel1,
    output logic [FW-1:0] fwd_sel2,
    output logic [CW-1:0] stall_count
);

    // Per-stage entries; index i is the instruction currently in stage i.
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] wb_en_q;
    logic [DEPTH-1:0] is_load_q;
    logic [RW-1:0]    dest_q [DEPTH];

    logic [CW-1:0]    stall_count_q;

    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;
    logic             hit_early;
    logic             load_use;
    logic             stall_raw;
    logic             issue_accept;
    logic [FW-1:0]    sel1;
    logic [FW-1:0]    sel2;

    // Per-stage source match: stage must hold a live register writer to the same register.
    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            match1[i] = src1_used & valid_q[i] & wb_en_q[i] & (dest_q[i] == src1);
            match2[i] = src2_used & valid_q[i] & wb_en_q[i] & (dest_q[i] == src2);
        end
    end

    // Hazard classification. The last stage never stalls: the register file
    // is written before it is read in the same cycle.
    always_comb begin
        hit_early = 1'b0;
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            hit_early = hit_early | match1[i] | match2[i];
        end
        load_use  = (match1[0] | match2[0]) & is_load_q[0];
        stall_raw = forward_en ? load_use : hit_early;
    end

    // Stall decision; flush, an empty decode slot or reset all suppress it.
    always_comb begin
        stall = rst & issue_valid & ~flush & stall_raw;
    end

    // Forward select: youngest matching stage wins, hence the descending scan.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            if (match1[i]) begin
                sel1 = FW'(i + 1);
            end
            if (match2[i]) begin
                sel2 = FW'(i + 1);
            end
        end
    end

    // Forwarding is only meaningful when enabled and the consumer actually proceeds.
    always_comb begin
        if (rst && forward_en && !stall) begin
            fwd_sel1 = sel1;
            fwd_sel2 = sel2;
        end else begin
            fwd_sel1 = '0;
            fwd_sel2 = '0;
        end
    end

    // A decode instruction enters stage 0 only when it is neither stalled nor killed.
    always_comb begin
        issue_accept = issue_valid & ~stall & ~flush;
    end

    // Shift the scoreboard one stage per cycle; stage 0 takes the new issue or a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= '0;
            wb_en_q   <= '0;
            is_load_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                dest_q[i] <= '0;
            end
        end else begin
            for (int i = int'(DEPTH) - 1; i > 0; i--) begin
                valid_q[i]   <= valid_q[i-1];
                wb_en_q[i]   <= wb_en_q[i-1];
                is_load_q[i] <= is_load_q[i-1];
                dest_q[i]    <= dest_q[i-1];
            end
            valid_q[0]   <= issue_accept;
            wb_en_q[0]   <= issue_wb_en;
            is_load_q[0] <= issue_is_load;
            dest_q[0]    <= issue_dest;
        end
    end

    // Saturating stall-cycle counter; one increment per stalled cycle regardless
    // of how many sources caused it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_q <= '0;
        end else if (stall && (stall_count_q != {CW{1'b1}})) begin
            stall_count_q <= stall_count_q + CW'(1);
        end
    end

    always_comb begin
        stall_count = stall_count_q;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by
// randomized traffic checked against a behavioural pipeline model.
module tb_hazard_scoreboard;

    localparam int D  = 3;
    localparam int CW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       issue_valid = 1'b0;
    logic       issue_wb_en = 1'b0;
    logic       issue_is_load = 1'b0;
    logic [3:0] issue_dest = '0;
    logic [3:0] src1 = '0;
    logic [3:0] src2 = '0;
    logic       src1_used = 1'b0;
    logic       src2_used = 1'b0;
    logic       forward_en = 1'b0;
    logic       flush = 1'b0;
    logic       stall;
    logic [1:0] fwd_sel1;
    logic [1:0] fwd_sel2;
    logic [3:0] stall_count;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(
        .NREG (16),
        .DEPTH(D),
        .CW   (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_wb_en  (issue_wb_en),
        .issue_is_load(issue_is_load),
        .issue_dest   (issue_dest),
        .src1         (src1),
        .src2         (src2),
        .src1_used    (src1_used),
        .src2_used    (src2_used),
        .forward_en   (forward_en),
        .flush        (flush),
        .stall        (stall),
        .fwd_sel1     (fwd_sel1),
        .fwd_sel2     (fwd_sel2),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    // Reference model: list of in-flight instructions, index = pipeline stage.
    typedef struct {
        bit v;
        bit w;
        bit l;
        int d;
    } inst_t;

    inst_t pipe [D];
    int    m_cnt;

    function automatic void m_clear();
        for (int k = 0; k < D; k++) pipe[k] = '{v: 0, w: 0, l: 0, d: 0};
        m_cnt = 0;
    endfunction

    function automatic bit m_reads(int k, int s, bit used);
        return used && pipe[k].v && pipe[k].w && (pipe[k].d == s);
    endfunction

    function automatic bit m_stall();
        bit hz = 0;
        if (!issue_valid || flush) return 0;
        if (forward_en) begin
            return pipe[0].l && (m_reads(0, int'(src1), src1_used) ||
                                 m_reads(0, int'(src2), src2_used));
        end
        for (int k = 0; k <= D - 2; k++) begin
            if (m_reads(k, int'(src1), src1_used) || m_reads(k, int'(src2), src2_used)) hz = 1;
        end
        return hz;
    endfunction

    function automatic int m_fwd(int s, bit used);
        if (!forward_en || m_stall()) return 0;
        for (int k = 0; k <= D - 2; k++) begin
            if (m_reads(k, s, used)) return k + 1;
        end
        return 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(bit iv, bit wb, bit ld, int dst, int s1, bit u1, int s2, bit u2,
                         bit fe, bit fl);
        issue_valid   = iv;
        issue_wb_en   = wb;
        issue_is_load = ld;
        issue_dest    = 4'(dst);
        src1          = 4'(s1);
        src1_used     = u1;
        src2          = 4'(s2);
        src2_used     = u2;
        forward_en    = fe;
        flush         = fl;
    endtask

    // Called just after a falling edge with inputs set: check outputs, then
    // advance model and DUT by one clock and return at the next falling edge.
    task automatic step();
        bit es;
        #1;
        es = m_stall();
        chk("stall", 32'(stall), 32'(es));
        chk("fwd_sel1", 32'(fwd_sel1), 32'(m_fwd(int'(src1), src1_used)));
        chk("fwd_sel2", 32'(fwd_sel2), 32'(m_fwd(int'(src2), src2_used)));
        chk("stall_count", 32'(stall_count), 32'(m_cnt));
        @(posedge clk);
        if (es && m_cnt < (1 << CW) - 1) m_cnt++;
        for (int k = D - 1; k > 0; k--) pipe[k] = pipe[k-1];
        if (issue_valid && !es && !flush)
            pipe[0] = '{v: 1, w: issue_wb_en, l: issue_is_load, d: int'(issue_dest)};
        else
            pipe[0] = '{v: 0, w: 0, l: 0, d: 0};
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m_clear();
        #2;
        rst = 1'b1;
    endtask

    initial begin
        int saved;
        bit hold;
        m_clear();
        @(negedge clk);

        // Reset state: outputs zero even with a would-be hazard presented.
        drive(1, 1, 0, 3, 3, 1, 3, 1, 0, 0);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fwd1", 32'(fwd_sel1), 32'd0);
        chk("rst_count", 32'(stall_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Stall-only producer/consumer on r3: two stall cycles, then issue.
        drive(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 0, 4, 3, 1, 0, 0, 0, 0);
        step();
        #1 chk("so_stall_c2", 32'(stall), 32'd1);
        step();
        #1 chk("so_stall_c3", 32'(stall), 32'd0);
        step();
        #1 chk("so_count", 32'(stall_count), 32'd2);

        // Forwarding from stage 0 then stage 1.
        do_reset();
        drive(1, 1, 0, 3, 0, 0, 0, 0, 1, 0);
        step();
        drive(1, 1, 0, 6, 1, 1, 3, 1, 1, 0);
        #1 chk("fw_s0_stall", 32'(stall), 32'd0);
        chk("fw_s0_sel2", 32'(fwd_sel2), 32'd1);
        step();
        drive(1, 1, 0, 7, 2, 0, 3, 1, 1, 0);
        #1 chk("fw_s1_sel2", 32'(fwd_sel2), 32'd2);
        step();

        // Load-use: one stall, then forward from stage 1.
        do_reset();
        drive(1, 1, 1, 5, 0, 0, 0, 0, 1, 0);
        step();
        drive(1, 1, 0, 8, 5, 1, 0, 0, 1, 0);
        #1 chk("lu_stall", 32'(stall), 32'd1);
        step();
        #1 chk("lu_stall_after", 32'(stall), 32'd0);
        chk("lu_sel1", 32'(fwd_sel1), 32'd2);
        step();

        // Flush on a load-use consumer: no stall, bubble into stage 0.
        do_reset();
        drive(1, 1, 1, 5, 0, 0, 0, 0, 1, 0);
        step();
        drive(1, 1, 0, 8, 5, 1, 0, 0, 1, 1);
        #1 chk("fl_stall", 32'(stall), 32'd0);
        saved = int'(stall_count);
        step();
        drive(1, 1, 0, 9, 5, 1, 8, 1, 1, 0);
        #1 chk("fl_bubble_sel1", 32'(fwd_sel1), 32'd2);
        chk("fl_bubble_sel2", 32'(fwd_sel2), 32'd0);
        chk("fl_count", 32'(stall_count), 32'(saved));
        step();

        // Saturation: ten stall-only pairs give 20 stall cycles; counter stops at 15.
        do_reset();
        for (int n = 0; n < 10; n++) begin
            drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
            step();
            drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
            repeat (3) step();
        end
        #1 chk("sat_count", 32'(stall_count), 32'd15);

        // Asynchronous reset in the middle of a stall.
        do_reset();
        drive(1, 1, 0, 2, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 0, 4, 2, 1, 0, 0, 0, 0);
        #1 chk("ar_pre_stall", 32'(stall), 32'd1);
        #1 rst = 1'b0;
        #1 chk("ar_stall", 32'(stall), 32'd0);
        chk("ar_count", 32'(stall_count), 32'd0);
        m_clear();
        @(negedge clk);
        rst = 1'b1;
        #1 chk("ar_no_stale", 32'(stall), 32'd0);
        step();

        // Randomized traffic; a stalled decode instruction is usually held.
        do_reset();
        hold = 0;
        for (int n = 0; n < 800; n++) begin
            if (!(hold && $urandom_range(9) != 0)) begin
                drive($urandom_range(7) != 0, $urandom_range(3) != 0, $urandom_range(2) == 0,
                      $urandom_range(3), $urandom_range(3), $urandom_range(3) != 0,
                      $urandom_range(3), $urandom_range(1) != 0,
                      $urandom_range(1) != 0, $urandom_range(15) == 0);
            end
            if ($urandom_range(99) == 0) do_reset();
            #1 hold = m_stall();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, 16, architectural register count; RW = clog2(NREG).
REQ-002 Parameter DEPTH, 3, tracked stages after issue (stage 0 = EX ... stage DEPTH-1 = WB); DEPTH range 2..8.
REQ-003 Parameter FW, clog2(DEPTH+1), width of the forward-select outputs.
REQ-004 Parameter CW, 16, stall counter width.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 issue_valid  in  1  decode presents an instruction this cycle.
REQ-008 issue_wb_en  in  1  the issued instruction writes a register.
REQ-009 issue_is_load  in  1  the issued instruction is a memory load.
REQ-010 issue_dest  in  RW  destination register of the issued instruction.
REQ-011 src1, src2  in  RW each  source registers of the decode instruction.
REQ-012 src1_used, src2_used  in  1 each  the corresponding source is actually read.
REQ-013 forward_en  in  1  1 = forwarding mode, 0 = stall-only mode.
REQ-014 flush  in  1  a branch was taken; kill the decode instruction.
REQ-015 stall  out  1  freeze IF/ID and insert a bubble into stage 0.
REQ-016 fwd_sel1, fwd_sel2  out  FW each  0 = register file, k = forward from stage k-1.
REQ-017 stall_count  out  CW  saturating count of stall cycles.

Function
REQ-018 The block SHALL hold DEPTH entries {valid, wb_en, is_load, dest}; entry i describes the instruction in stage i.
REQ-019 Each cycle, entries SHALL shift i -> i+1; entry DEPTH-1 SHALL be discarded.
REQ-020 Entry 0 SHALL load {1, issue_wb_en, issue_is_load, issue_dest} when issue_valid=1, stall=0 and flush=0; otherwise it SHALL load a bubble (valid=0).
REQ-021 A source matches stage i when its used bit=1, entry i has valid=1 and wb_en=1, and dest equals the source.
REQ-022 Stall-only mode: stall SHALL be 1 iff any source matches any stage 0..DEPTH-2; a match in stage DEPTH-1 SHALL NOT stall, because the register file writes before it is read.
REQ-023 Forwarding mode: stall SHALL be 1 iff any source matches stage 0 and entry 0 has is_load=1 (load-use).
REQ-024 Forwarding mode, no stall: fwd_selN SHALL equal k+1, where k is the lowest (youngest) matching stage in 0..DEPTH-2; fwd_selN SHALL be 0 if no stage matches.
REQ-025 fwd_sel1 and fwd_sel2 SHALL be 0 whenever forward_en=0 or stall=1.
REQ-026 stall, fwd_sel1 and fwd_sel2 SHALL be combinational from the current entries and inputs, with zero-cycle latency.
REQ-027 flush=1 SHALL force stall=0 and insert a bubble into stage 0; entries 1..DEPTH-1 SHALL shift unchanged.
REQ-028 issue_valid=0 SHALL force stall=0.
REQ-029 stall_count SHALL increment by 1 on each cycle with stall=1, and SHALL hold at 2^CW-1 once it reaches that value.
REQ-030 The block SHALL count a stall in which both sources match as one stall cycle.
REQ-031 If register r appears in several stages, the youngest stage SHALL win for forwarding.

Reset
REQ-032 When rst=0, the block SHALL immediately clear every entry valid bit and stall_count to 0, regardless of clk.
REQ-033 During reset, stall, fwd_sel1 and fwd_sel2 SHALL read 0.
REQ-034 Reset asserted mid-stall SHALL abandon the stall; the first post-reset issue SHALL see an empty scoreboard.

Verification
REQ-035 Stall-only, DEPTH=3: issue ADD r3, then SUB using src1=r3 -> stall=1 for 2 cycles; SUB enters stage 0 on cycle 3; stall_count=2.
REQ-036 Forwarding: issue ADD r3, then ORR using src2=r3 -> stall=0, fwd_sel2=1; one cycle later, with the consumer using r3 -> fwd_sel2=2.
REQ-037 Forwarding, load-use: issue LDR r5, then ADD using src1=r5 -> stall=1 for 1 cycle, then fwd_sel1=2, stall=0.
REQ-038 Flush during stall: issue LDR r5 with a dependent consumer and flush=1 -> stall=0; stage 0 holds a bubble; stall_count unchanged.
REQ-039 Saturation, CW=4: hold a dependency for 20 cycles -> stall_count stops at 15.
REQ-040 Reset mid-operation: assert rst=0 between clock edges -> entries and stall_count read 0 at once; the next dependent pair sees no stale match.
